// File: rtl/adc_ctrl_pkg.sv
// adc_ctrl_pkg: FSM state type and default timing constants for the AD7822 controller
package adc_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, CONV, WAIT_EOC, READ, DONE} state_e;
  localparam int SAMPLE_DIV_DEF  = 2500;
  localparam int CONVST_CYC_DEF  = 2;
  localparam int RD_CYC_DEF      = 3;
  localparam int EOC_TIMEOUT_DEF = 64;
endpackage

// File: rtl/adc_ctrl_eoc_sync.sv
// eoc_sync: brings the asynchronous end-of-conversion strobe into clk and flags its falling edge
module eoc_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic adc_eoc_n,
  output logic eoc_fall
);
  logic [2:0] sync_q;
  // two metastability stages then one history stage; all idle high
  always_ff @(posedge clk) begin
    if (!reset_n) sync_q <= 3'b111;
    else sync_q <= {sync_q[1:0], adc_eoc_n};
  end
  assign eoc_fall = sync_q[2] & ~sync_q[1];
endmodule

// File: rtl/adc_ctrl.sv
// adc_ctrl: periodic AD7822 conversion sequencer with valid/ready sample output and sticky errors
module adc_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int SAMPLE_DIV  = SAMPLE_DIV_DEF,
  parameter int CONVST_CYC  = CONVST_CYC_DEF,
  parameter int RD_CYC      = RD_CYC_DEF,
  parameter int EOC_TIMEOUT = EOC_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sample_en,
  input  logic [7:0] adc_db,
  input  logic       adc_eoc_n,
  output logic       adc_convst_n,
  output logic       adc_cs_n,
  output logic       adc_rd_n,
  output logic [7:0] sample_data,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic       overrun,
  output logic       timeout_err,
  input  logic       err_clr
);
  localparam int CW = $clog2(SAMPLE_DIV + 1);
  localparam int TW = 16;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] cyc_q, cyc_d;
  logic [7:0] rd_data_q, data_q;
  logic convst_n_q, cs_n_q, rd_n_q, valid_q, ovr_q, to_q;
  logic tick, eoc_fall, timeout;

  eoc_sync u_eoc_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .adc_eoc_n (adc_eoc_n),
    .eoc_fall  (eoc_fall)
  );

  assign tick    = cnt_q == CW'(SAMPLE_DIV - 1);
  assign timeout = state_q == WAIT_EOC && !eoc_fall && cyc_q == TW'(EOC_TIMEOUT - 1);

  // sequence IDLE -> CONV -> WAIT_EOC -> READ -> DONE; cyc_q counts cycles spent in the current state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (tick && sample_en) state_d = CONV;
      CONV:     if (cyc_q == TW'(CONVST_CYC - 1)) state_d = WAIT_EOC;
      WAIT_EOC: state_d = eoc_fall ? READ : timeout ? IDLE : WAIT_EOC;
      READ:     if (cyc_q == TW'(RD_CYC - 1)) state_d = DONE;
      default:  state_d = IDLE;
    endcase
    cyc_d = (state_d == state_q) ? cyc_q + TW'(1) : '0;
  end

  // strobes are registered from the next state so they line up exactly with CONV and READ
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cyc_q      <= '0;
      convst_n_q <= 1'b1;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      rd_data_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= tick ? '0 : cnt_q + CW'(1);
      cyc_q      <= cyc_d;
      convst_n_q <= state_d != CONV;
      cs_n_q     <= state_d != READ;
      rd_n_q     <= state_d != READ;
      if (state_q == READ && state_d == DONE) rd_data_q <= adc_db;
      if (state_q == DONE) data_q <= rd_data_q;
      valid_q    <= state_q == DONE || (valid_q && !sample_ready);
      ovr_q      <= (state_q == DONE && valid_q && !sample_ready) || (ovr_q && !err_clr);
      to_q       <= timeout || (to_q && !err_clr);
    end
  end

  assign adc_convst_n = convst_n_q;
  assign adc_cs_n     = cs_n_q;
  assign adc_rd_n     = rd_n_q;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
  assign timeout_err  = to_q;
endmodule

// File: doc/adc_ctrl.md
ADC_CTRL -- requirements
Module: adc_ctrl

Interface
REQ-001 The block SHALL have parameter SAMPLE_DIV, default 2500, giving the clk cycles per sample period (20 kHz at 50 MHz).
REQ-002 The block SHALL have parameter CONVST_CYC, default 2, giving the adc_convst_n low width in cycles.
REQ-003 The block SHALL have parameter RD_CYC, default 3, giving the adc_cs_n/adc_rd_n low width in cycles.
REQ-004 The block SHALL have parameter EOC_TIMEOUT, default 64, giving the maximum cycles spent waiting for end of conversion.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port reset_n, input, 1 bit: the reset, synchronous and active-low.
REQ-007 The block SHALL have port sample_en, input, 1 bit: enables periodic conversions.
REQ-008 The block SHALL have port adc_db, input, 8 bits: AD7822 data bus.
REQ-009 The block SHALL have port adc_eoc_n, input, 1 bit: AD7822 end of conversion, asynchronous to clk.
REQ-010 The block SHALL have port adc_convst_n, output, 1 bit: AD7822 convert start.
REQ-011 The block SHALL have ports adc_cs_n and adc_rd_n, output, 1 bit each: AD7822 chip select and read.
REQ-012 The block SHALL have port sample_data, output, 8 bits: captured sample for the filter.
REQ-013 The block SHALL have ports sample_valid (output, 1 bit) and sample_ready (input, 1 bit) forming the downstream valid/ready handshake.
REQ-014 The block SHALL have ports overrun and timeout_err, output, 1 bit each: sticky error flags.
REQ-015 The block SHALL have port err_clr, input, 1 bit: clears both sticky flags.

Function
REQ-016 A free-running period counter SHALL count 0..SAMPLE_DIV-1 and wrap, issuing a one-cycle tick at SAMPLE_DIV-1.
REQ-017 The FSM SHALL have exactly the states IDLE, CONV, WAIT_EOC, READ and DONE.
REQ-018 IDLE SHALL go to CONV on a tick with sample_en=1; a tick arriving in any other state SHALL be ignored.
REQ-019 In CONV, adc_convst_n SHALL be low for exactly CONVST_CYC cycles, starting the cycle after the tick; the FSM then goes to WAIT_EOC.
REQ-020 adc_eoc_n SHALL pass through a 2-flop synchronizer followed by falling-edge detection; WAIT_EOC goes to READ on the detected edge.
REQ-021 If WAIT_EOC lasts EOC_TIMEOUT cycles with no edge, the block SHALL set timeout_err, return to IDLE and produce no sample.
REQ-022 In READ, adc_cs_n and adc_rd_n SHALL both be low for exactly RD_CYC cycles; adc_db is registered on the last low cycle.
REQ-023 DONE SHALL last one cycle: it loads sample_data, sets sample_valid, then returns to IDLE.
REQ-024 sample_valid SHALL stay high until a cycle with sample_ready=1, then clear; sample_data SHALL be stable while sample_valid=1 except as stated in REQ-025.
REQ-025 If DONE occurs while sample_valid=1 and sample_ready=0, the new sample SHALL overwrite sample_data and overrun SHALL be set.
REQ-026 If DONE coincides with sample_ready=1, the new sample SHALL load, sample_valid SHALL stay high and overrun SHALL NOT be set.
REQ-027 If err_clr and a new error event occur in the same cycle, the error SHALL win and the flag SHALL be set.
REQ-028 When sample_en deasserts mid-conversion, the conversion in progress SHALL complete and no new conversion SHALL start.
REQ-029 All ADC control outputs SHALL be registered, and adc_cs_n/adc_rd_n SHALL never be low while adc_convst_n is low.

Reset
REQ-030 When reset_n=0 at a clk edge, the block SHALL on that edge set: state IDLE, period counter 0, adc_convst_n/adc_cs_n/adc_rd_n = 1, sample_data = 0x00, sample_valid/overrun/timeout_err = 0, synchronizer flops = 1.
REQ-031 Reset asserted mid-CONV or mid-READ SHALL deassert all ADC strobes on the same edge and discard any partial sample.

Structure
REQ-032 Package adc_ctrl_pkg SHALL hold the FSM state enum typedef and the default parameter constants.
REQ-033 Sub-module eoc_sync SHALL implement the 2-flop synchronizer and falling-edge pulse; all other logic SHALL reside in adc_ctrl.

Verification
REQ-034 Bench SHALL use SAMPLE_DIV=50 with sample_ready=1: adc_convst_n low exactly 2 cycles, repeating every 50 cycles.
REQ-035 Bench SHALL drive AD7822 model input 2.5 V with VDD 5 V: sample_data=0x80 with sample_valid high 1 cycle; cs_n/rd_n low exactly 3 cycles.
REQ-036 Bench SHALL hold adc_eoc_n high: timeout_err=1 at tick+1+2+64 cycles, no sample_valid, next tick starts a new CONV.
REQ-037 Bench SHALL hold sample_ready=0 across two periods with inputs 1.0 V then 4.0 V: overrun=1, sample_data=0xCC; err_clr then gives overrun=0.
REQ-038 Bench SHALL assert reset_n=0 during READ: next edge has cs_n=rd_n=1, sample_valid=0, state IDLE.
REQ-039 Bench SHALL deassert sample_en during WAIT_EOC: that sample is delivered, then no adc_convst_n pulse occurs for 3 periods.
